// File: rtl/accum_table.sv
// accum_table: per-lane accumulator table below the systolic array, with a
//   self-clearing sweep after reset and on request.
// Latency: writes/accumulates take effect at the rising edge; reads are registered (1 cycle).
// Backpressure: none; wr_en/rd_en are dropped while busy is high.
//
// Ports:
//   clk, reset (async, active-low)
//   clear_req -> busy, clear_done       : full-table zeroing sweep, one row per cycle
//   wr_en, wr_mode, wr_mask, wr_addr, wr_data : overwrite (mode 0) or accumulate (mode 1)
//                                          per masked lane; lane 0 in the LSBs
//   rd_en, rd_addr -> rd_data, rd_valid : whole-row read, read-before-write on collision
//   sat_flag (ACCUM_SAT_EN only)        : lanes that saturated on the last accepted write
//
// Optional build macro ACCUM_SAT_EN: accumulate saturates instead of wrapping.
// ACC_WIDTH must be >= DATA_WIDTH.
module accum_table #(
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_COLS = 16,
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int AW = $clog2(NUM_ACCUM_ROWS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear_req,
  output logic                               busy,
  output logic                               clear_done,
  input  logic                               wr_en,
  input  logic                               wr_mode,
  input  logic [SYS_ARR_COLS-1:0]            wr_mask,
  input  logic [AW-1:0]                      wr_addr,
  input  logic [SYS_ARR_COLS*DATA_WIDTH-1:0] wr_data,
`ifdef ACCUM_SAT_EN
  output logic [SYS_ARR_COLS-1:0]            sat_flag,
`endif
  input  logic                               rd_en,
  input  logic [AW-1:0]                      rd_addr,
  output logic [SYS_ARR_COLS*ACC_WIDTH-1:0]  rd_data,
  output logic                               rd_valid
);

  localparam int ROW_W = SYS_ARR_COLS * ACC_WIDTH;
  localparam logic [AW-1:0] LAST_ROW = AW'(NUM_ACCUM_ROWS - 1);
  // One extra bit so out-of-range addresses can be detected for non-power-of-2 depths.
  localparam logic [AW:0]   DEPTH    = (AW+1)'(NUM_ACCUM_ROWS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;

  logic [ROW_W-1:0] mem [NUM_ACCUM_ROWS];

  logic             wr_in_range, rd_in_range;
  logic             wr_ok, rd_ok;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [ROW_W-1:0] wr_row_old, wr_row_new;

  // ---------------------------------------------------------------- clear FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    busy        = 1'b0;
    clear_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      ST_CLEAR: begin
        // clear_req is deliberately not looked at here: a sweep never restarts.
        busy = 1'b1;
        if (clr_cnt == LAST_ROW) begin
          clear_done  = 1'b1;
          state_nxt   = ST_IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + AW'(1);
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------- access qualification
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH);
  assign wr_ok       = !busy && wr_en && wr_in_range;
  assign rd_ok       = !busy && rd_en;
  // Park the index on row 0 when out of range so the array is never indexed past its end.
  assign wr_idx      = wr_in_range ? wr_addr : '0;
  assign rd_idx      = rd_in_range ? rd_addr : '0;

  // Read-modify-write happens entirely within one cycle from the array itself,
  // so back-to-back accumulates to one row always see the previous result.
  assign wr_row_old  = mem[wr_idx];

`ifdef ACCUM_SAT_EN
  logic [SYS_ARR_COLS-1:0] lane_sat;
`endif

  for (genvar i = 0; i < SYS_ARR_COLS; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] din;
    logic signed [ACC_WIDTH-1:0]  ext_v, old_v, sum_v, acc_v, nxt_v;

    assign din   = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign ext_v = ACC_WIDTH'(din);   // signed cast: sign-extends the partial sum
    assign old_v = wr_row_old[i*ACC_WIDTH +: ACC_WIDTH];
    assign sum_v = old_v + ext_v;

`ifdef ACCUM_SAT_EN
    logic ovf;
    // Overflow only when both operands share a sign and the result's sign differs.
    assign ovf   = (old_v[ACC_WIDTH-1] == ext_v[ACC_WIDTH-1]) &&
                   (sum_v[ACC_WIDTH-1] != old_v[ACC_WIDTH-1]);
    assign acc_v = !ovf               ? sum_v :
                   old_v[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                        {1'b0, {(ACC_WIDTH-1){1'b1}}};
    assign lane_sat[i] = wr_mask[i] && wr_mode && ovf;
`else
    assign acc_v = sum_v;
`endif

    assign nxt_v = !wr_mask[i] ? old_v : (wr_mode ? acc_v : ext_v);
    assign wr_row_new[i*ACC_WIDTH +: ACC_WIDTH] = nxt_v;
  end

  // ---------------------------------------------------------------- storage
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      mem[wr_idx] <= wr_row_new;
    end
  end

  // Same-edge sampling of mem gives read-before-write on an address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_ok) begin
      rd_valid <= 1'b1;
      rd_data  <= rd_in_range ? mem[rd_idx] : '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

`ifdef ACCUM_SAT_EN
  // Reflects only the most recent accepted write; a write without overflow clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= '0;
    end else if (wr_ok) begin
      sat_flag <= lane_sat;
    end
  end
`endif

endmodule

// File: tb/tb_accum_table.sv
// Bench for accum_table at depth 32, 4 lanes, 8-bit data, 12-bit accumulators.
module tb_accum_table;
  localparam int DW    = 8;
  localparam int AWID  = 12;
  localparam int LANES = 4;
  localparam int DEPTH = 32;
  localparam int ABITS = 5;
  localparam int ACC_MOD = 1 << AWID;
  localparam int ACC_MAX = (1 << (AWID - 1)) - 1;
  localparam int ACC_MIN = -(1 << (AWID - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset, clear_req, wr_en, wr_mode, rd_en;
  logic [LANES-1:0]      wr_mask;
  logic [ABITS-1:0]      wr_addr, rd_addr;
  logic [LANES*DW-1:0]   wr_data;
  logic                  busy, clear_done, rd_valid;
  logic [LANES*AWID-1:0] rd_data;
`ifdef ACCUM_SAT_EN
  logic [LANES-1:0]      sat_flag;
`endif

  int total  = 0;
  int passed = 0;
  int model [DEPTH][LANES];
  logic [LANES-1:0] exp_sat;

  accum_table #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AWID), .MAX_OUT_ROWS(8),
    .MAX_OUT_COLS(16), .SYS_ARR_COLS(LANES)
  ) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
    .clear_done(clear_done), .wr_en(wr_en), .wr_mode(wr_mode),
    .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef ACCUM_SAT_EN
    .sat_flag(sat_flag),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  // ---------------------------------------------------------------- reference model
  function automatic int wrap_acc(input int v);
    int r;
    r = v % ACC_MOD;
    if (r < 0) r += ACC_MOD;
    if (r > ACC_MAX) r -= ACC_MOD;
    return r;
  endfunction

  function automatic void model_clear();
    for (int a = 0; a < DEPTH; a++)
      for (int i = 0; i < LANES; i++) model[a][i] = 0;
  endfunction

  function automatic void model_write(input logic mode, input logic [LANES-1:0] mask,
                                      input int addr, input int d[LANES]);
    int s;
    exp_sat = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        if (!mode) begin
          model[addr][i] = d[i];
        end else begin
          s = model[addr][i] + d[i];
`ifdef ACCUM_SAT_EN
          if (s > ACC_MAX) begin s = ACC_MAX; exp_sat[i] = 1'b1; end
          else if (s < ACC_MIN) begin s = ACC_MIN; exp_sat[i] = 1'b1; end
`else
          s = wrap_acc(s);
`endif
          model[addr][i] = s;
        end
      end
    end
  endfunction

  function automatic logic [LANES*AWID-1:0] exp_row(input int a);
    logic [LANES*AWID-1:0] row;
    int v;
    row = '0;
    for (int i = 0; i < LANES; i++) begin
      v = model[a][i];
      row[i*AWID +: AWID] = v[AWID-1:0];
    end
    return row;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic mode, input logic [LANES-1:0] mask,
                       input int waddr, input int d[LANES], input logic re, input int raddr);
    int t;
    wr_en = we; wr_mode = mode; wr_mask = mask; rd_en = re;
    wr_addr = waddr[ABITS-1:0];
    rd_addr = raddr[ABITS-1:0];
    for (int i = 0; i < LANES; i++) begin
      t = d[i];
      wr_data[i*DW +: DW] = t[DW-1:0];
    end
    step();
    wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
  endtask

  task automatic wr(input logic mode, input logic [LANES-1:0] mask, input int addr,
                    input int d[LANES]);
    model_write(mode, mask, addr, d);
    drive(1'b1, mode, mask, addr, d, 1'b0, 0);
  endtask

  task automatic rd(input int addr);
    int z[LANES];
    z = '{default: 0};
    drive(1'b0, 1'b0, '0, 0, z, 1'b1, addr);
  endtask

  // Samples busy/clear_done/rd_valid for 40 cycles from now; optionally hammers
  // the ports with writes, reads and a repeated clear_req while busy.
  task automatic measure_sweep(input logic junk, output int nb, output int da,
                               output int nd, output int nv);
    int d5[LANES];
    d5 = '{5, 5, 5, 5};
    nb = 0; da = -1; nd = 0; nv = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) nb++;
      if (clear_done) begin nd++; if (da < 0) da = c; end
      if (rd_valid) nv++;
      if (junk && busy) begin
        if (c == 10) clear_req = 1'b1;
        drive(1'b1, 1'b1, 4'hF, (c >= 2) ? c - 2 : DEPTH - 1, d5, 1'b1, 0);
      end else begin
        step();
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    model_clear();
    for (int r = 0; r < DEPTH; r++) begin
      rd(r);
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_row(r))
        $display("FAIL %s row %0d: got valid=%b data=%h, expected valid=1 data=%h",
                 tag, r, rd_valid, rd_data, exp_row(r));
      else passed++;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    int nb, da, nd, nv;
    reset = 1'b0; clear_req = 1'b0; wr_en = 1'b0; wr_mode = 1'b0; wr_mask = '0;
    wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) step();
    total++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy); else passed++;
    total++; if (clear_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", clear_done); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rd_valid); else passed++;
    total++; if (rd_data !== '0) $display("FAIL reset_data: got %h expected 0", rd_data); else passed++;
    reset = 1'b1;
    measure_sweep(1'b0, nb, da, nd, nv);
    total++; if (nb !== 32) $display("FAIL sweep_len: got %0d expected 32", nb); else passed++;
    total++; if (da !== 32) $display("FAIL sweep_done_cycle: got %0d expected 32", da); else passed++;
    total++; if (nd !== 1) $display("FAIL sweep_done_pulses: got %0d expected 1", nd); else passed++;
    check_all_zero("sweep_zero");
  endtask

  task automatic test_accumulate();
    int d[LANES];
    logic [LANES*AWID-1:0] held;
    d = '{1, 2, 3, -1};
    repeat (4) wr(1'b1, 4'hF, 5, d);
    total++; if (rd_valid !== 1'b0) $display("FAIL acc_valid_pre: got %b expected 0", rd_valid); else passed++;
    rd(5);
    held = exp_row(5);
    total++; if (rd_valid !== 1'b1) $display("FAIL acc_valid: got %b expected 1", rd_valid); else passed++;
    total++; if (rd_data !== held) $display("FAIL acc_data: got %h expected %h", rd_data, held); else passed++;
    step();
    total++; if (rd_valid !== 1'b0) $display("FAIL acc_valid_drop: got %b expected 0", rd_valid); else passed++;
    total++; if (rd_data !== held) $display("FAIL acc_hold: got %h expected %h", rd_data, held); else passed++;
  endtask

  task automatic test_mask_overwrite();
    int d[LANES];
    d = '{1, 1, 1, 1};
    wr(1'b0, 4'hF, 7, d);
    d = '{10, 20, 30, 40};
    wr(1'b0, 4'b0101, 7, d);
    rd(7);
    total++;
    if (rd_data !== exp_row(7)) $display("FAIL mask_overwrite: got %h expected %h", rd_data, exp_row(7));
    else passed++;
  endtask

  task automatic test_read_before_write();
    int d[LANES];
    logic [LANES*AWID-1:0] pre;
    d = '{7, 7, 7, 7};
    wr(1'b0, 4'hF, 3, d);
    pre = exp_row(3);
    d = '{5, 5, 5, 5};
    model_write(1'b1, 4'hF, 3, d);
    drive(1'b1, 1'b1, 4'hF, 3, d, 1'b1, 3);
    total++; if (rd_data !== pre) $display("FAIL rbw_old: got %h expected %h", rd_data, pre); else passed++;
    rd(3);
    total++; if (rd_data !== exp_row(3)) $display("FAIL rbw_new: got %h expected %h", rd_data, exp_row(3)); else passed++;
  endtask

  task automatic test_overflow();
    int d[LANES];
    d = '{127, 0, 0, 0};
    repeat (15) wr(1'b1, 4'b0001, 9, d);
    d = '{95, 0, 0, 0};
    wr(1'b1, 4'b0001, 9, d);
    rd(9);
    total++; if (rd_data !== exp_row(9)) $display("FAIL ovf_base: got %h expected %h", rd_data, exp_row(9)); else passed++;
    d = '{127, 0, 0, 0};
    wr(1'b1, 4'b0001, 9, d);
`ifdef ACCUM_SAT_EN
    total++; if (sat_flag !== exp_sat) $display("FAIL ovf_sat_flag: got %b expected %b", sat_flag, exp_sat); else passed++;
`endif
    rd(9);
    total++; if (rd_data !== exp_row(9)) $display("FAIL ovf_result: got %h expected %h", rd_data, exp_row(9)); else passed++;
`ifdef ACCUM_SAT_EN
    d = '{0, 0, 0, 0};
    wr(1'b0, 4'b0001, 9, d);
    total++; if (sat_flag !== exp_sat) $display("FAIL sat_flag_clear: got %b expected %b", sat_flag, exp_sat); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    int d[LANES];
    logic we, mode, re;
    logic [LANES-1:0] mask;
    int wa, ra;
    logic [LANES*AWID-1:0] exp_rd, last_rd;
    rd(0);
    last_rd = exp_row(0);
    total++; if (rd_data !== last_rd) $display("FAIL b2b_start: got %h expected %h", rd_data, last_rd); else passed++;
    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      re   = 1'($urandom_range(0, 1));
      mask = 4'($urandom_range(0, 15));
      wa   = $urandom_range(0, 3);
      ra   = $urandom_range(0, 3);
      for (int i = 0; i < LANES; i++) d[i] = int'($urandom_range(0, 255)) - 128;
      exp_rd = re ? exp_row(ra) : last_rd;
      if (we) model_write(mode, mask, wa, d);
      drive(we, mode, mask, wa, d, re, ra);
      total++;
      if (rd_valid !== re || rd_data !== exp_rd)
        $display("FAIL b2b_%0d: got valid=%b data=%h, expected valid=%b data=%h",
                 n, rd_valid, rd_data, re, exp_rd);
      else passed++;
      last_rd = exp_rd;
`ifdef ACCUM_SAT_EN
      if (we) begin
        total++;
        if (sat_flag !== exp_sat) $display("FAIL b2b_sat_%0d: got %b expected %b", n, sat_flag, exp_sat);
        else passed++;
      end
`endif
    end
  endtask

  task automatic test_clear_mid();
    int d[LANES];
    int nb, da, nd, nv;
    d = '{11, -22, 33, -44};
    wr(1'b0, 4'hF, 0, d);
    wr(1'b0, 4'hF, 31, d);
    total++; if (busy !== 1'b0) $display("FAIL clr_idle: got %b expected 0", busy); else passed++;
    clear_req = 1'b1;
    wr(1'b0, 4'hF, 2, d);
    total++; if (busy !== 1'b1) $display("FAIL clr_busy_next: got %b expected 1", busy); else passed++;
    measure_sweep(1'b1, nb, da, nd, nv);
    total++; if (nb !== 32) $display("FAIL clr_len: got %0d expected 32", nb); else passed++;
    total++; if (da !== 32) $display("FAIL clr_done_cycle: got %0d expected 32", da); else passed++;
    total++; if (nd !== 1) $display("FAIL clr_done_pulses: got %0d expected 1", nd); else passed++;
    total++; if (nv !== 0) $display("FAIL clr_rd_valid: got %0d expected 0", nv); else passed++;
    check_all_zero("clr_zero");
  endtask

  task automatic test_reset_mid();
    int d[LANES];
    int nb, da, nd, nv;
    d = '{3, 4, 5, 6};
    wr(1'b0, 4'hF, 4, d);
    wr(1'b0, 4'hF, 20, d);
    rd(4);
    reset = 1'b0;
    #1;
    total++; if (rd_valid !== 1'b0) $display("FAIL rstrd_valid: got %b expected 0", rd_valid); else passed++;
    total++; if (rd_data !== '0) $display("FAIL rstrd_data: got %h expected 0", rd_data); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL rstrd_busy: got %b expected 1", busy); else passed++;
    step();
    reset = 1'b1;
    measure_sweep(1'b0, nb, da, nd, nv);
    total++; if (nb !== 32 || da !== 32) $display("FAIL rstrd_sweep: got len %0d done %0d expected 32/32", nb, da); else passed++;
    wr(1'b0, 4'hF, 4, d);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (9) step();
    reset = 1'b0;
    #1;
    total++; if (clear_done !== 1'b0 || busy !== 1'b1) $display("FAIL rstsw_state: got done=%b busy=%b expected 0/1", clear_done, busy); else passed++;
    step();
    reset = 1'b1;
    measure_sweep(1'b0, nb, da, nd, nv);
    total++; if (nb !== 32) $display("FAIL rstsw_len: got %0d expected 32", nb); else passed++;
    total++; if (da !== 32 || nd !== 1) $display("FAIL rstsw_done: got cycle %0d pulses %0d expected 32/1", da, nd); else passed++;
    check_all_zero("rstsw_zero");
  endtask

  initial begin
    model_clear();
    exp_sat = '0;
    test_reset();
    test_accumulate();
    test_mask_overwrite();
    test_read_before_write();
    test_overflow();
    test_back_to_back();
    test_clear_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/accum_table.md
Name: accum_table

Overview:
- Multi-column accumulator table that sits below the systolic array and collects partial sums.
- Each of SYS_ARR_COLS lanes owns NUM_ACCUM_ROWS accumulator entries of ACC_WIDTH bits.
- The write port either accumulates into an entry or overwrites it, per lane via a mask. The read port returns a whole row with one-cycle registered latency.
- A built-in clear state machine zeroes the table after reset and on request, replacing the single-lane, single-width column with a wider, maskable, self-clearing table.

Parameters:
- DATA_WIDTH, 8, width of one incoming partial sum (signed two's complement)
- ACC_WIDTH, 24, width of one stored accumulator entry (signed); must be >= DATA_WIDTH
- MAX_OUT_ROWS, 128, output height of largest matrix
- MAX_OUT_COLS, 128, output width of largest matrix
- SYS_ARR_COLS, 16, number of lanes (systolic array width)
- localparam NUM_ACCUM_ROWS = MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS)
- localparam AW = $clog2(NUM_ACCUM_ROWS)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- clear_req  in  1  request a full-table clear sweep (pulse)
- busy  out  1  high while a clear sweep runs
- clear_done  out  1  one-cycle pulse on the final sweep write
- wr_en  in  1  write/accumulate strobe
- wr_mode  in  1  0 = overwrite, 1 = accumulate
- wr_mask  in  SYS_ARR_COLS  per-lane write enable
- wr_addr  in  AW  row address
- wr_data  in  SYS_ARR_COLS*DATA_WIDTH  packed lane data, lane 0 in LSBs
- rd_en  in  1  read strobe
- rd_addr  in  AW  row address
- rd_data  out  SYS_ARR_COLS*ACC_WIDTH  packed row, lane 0 in LSBs
- rd_valid  out  1  rd_data valid this cycle

Behaviour:
- Reset asserted:
  - FSM forced to CLEAR with row counter 0.
  - busy=1, clear_done=0, rd_valid=0, rd_data=0.
  - Table contents are undefined until the sweep completes.
- FSM states IDLE and CLEAR:
  - CLEAR: each cycle writes 0 to all lanes of row counter, then increments the counter.
  - On counter==NUM_ACCUM_ROWS-1: write row, pulse clear_done, go to IDLE next edge.
  - The sweep lasts exactly NUM_ACCUM_ROWS cycles after reset release.
  - IDLE: clear_req=1 -> CLEAR with counter 0 next edge. busy rises the cycle after clear_req.
  - clear_req while in CLEAR is ignored; the sweep does not restart.
- While busy=1, wr_en and rd_en are ignored: no table update, rd_valid stays 0.
- Write (IDLE, wr_en=1), for each lane i with wr_mask[i]=1, at the rising edge:
  - overwrite: entry = sign-extend(wr_data lane i)
  - accumulate: entry = entry + sign-extend(wr_data lane i), modulo 2^ACC_WIDTH (wraps)
  - Lanes with mask 0 are unchanged.
- Back-to-back accumulates to the same address on consecutive cycles are fully correct: each sees the previous result, with no hazard.
- Read (IDLE, rd_en=1):
  - rd_data is registered from rd_addr. rd_valid=1 in the following cycle; latency is 1.
  - rd_data holds its last value when rd_valid=0.
- Read and write to the same address in the same cycle: the read returns the pre-write value (read-before-write).
- Addresses >= NUM_ACCUM_ROWS, possible only when NUM_ACCUM_ROWS is not a power of 2:
  - writes are dropped;
  - reads return 0 with rd_valid=1.
- Reset asserted mid-sweep or mid-read: immediately returns to the reset state above, and a new sweep starts on release.

Optional Feature:
- Macro ACCUM_SAT_EN.
- When defined: accumulate mode saturates per lane to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Overflow is detected from the operand and result signs. An extra output sat_flag (SYS_ARR_COLS bits) is registered high for lanes that saturated on that write, and cleared on the next write or by reset.
- When undefined: accumulate wraps modulo 2^ACC_WIDTH and sat_flag does not exist.

Test Plan:
- Test parameters: MAX_OUT_ROWS=8, MAX_OUT_COLS=16, SYS_ARR_COLS=4, DATA_WIDTH=8, ACC_WIDTH=12, so depth = 32.
- Reset/clear sweep: release reset -> busy=1 for exactly 32 cycles, clear_done pulses on cycle 32. Reading rows 0..31 then returns all lanes 0.
- Accumulate: four consecutive accumulates of lane data {1,2,3,-1} to addr 5, mask 4'b1111 -> read addr 5 gives {4,8,12,-4}, rd_valid one cycle after rd_en.
- Mask and overwrite: overwrite addr 7 with {10,20,30,40} mask 4'b0101, after a prior value of {1,1,1,1} -> read gives {10,1,30,1}.
- Read-before-write: same-cycle rd and accumulate +5 to addr 3 holding 7 -> rd_data lane 0 = 7; the next read gives 12.
- Overflow: accumulate +127 into an entry holding 2000, ACC_WIDTH=12:
  - without ACCUM_SAT_EN -> -1969 (2127 wrapped);
  - with ACCUM_SAT_EN -> 2047 and sat_flag[0]=1.
- Mid-operation clear: clear_req while writing -> busy next cycle, writes ignored during the sweep. After 32 cycles clear_done pulses and the table is all 0. Reset asserted mid-sweep restarts the sweep from row 0 after release.
